// File: rtl/word40_assembler_pkg.sv
// Shared constants, state encoding and parity helper for the byte-to-word packer.
// Optional parity checking is enabled by defining ASM_PARITY_EN.
`ifndef WORD40_ASSEMBLER_DEFS
`define WORD40_ASSEMBLER_DEFS
`define ASM_BYTE_W 8
`define ASM_WORD_W 40
`endif

package word40_assembler_pkg;

  typedef enum logic {
    ASM_S_FILL = 1'b0,
    ASM_S_FULL = 1'b1
  } asm_state_e;

  localparam int ASM_CNT_W = 3;

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic asm_par_bad(input logic [`ASM_BYTE_W-1:0] data, input logic par);
    return (^data) != par;
  endfunction

endpackage

// File: rtl/word40_assembler_if.sv
// Byte-in / word-out bus of the packer. The master side feeds bytes and the stall,
// the slave side is the packer. Parity signals exist only with ASM_PARITY_EN.
interface word40_assembler_if;
  logic [`ASM_BYTE_W-1:0] in_byte;
  logic                   in_valid;
  logic                   in_ready;
  logic                   flush;
  logic                   out_stall;
  logic [`ASM_WORD_W-1:0] out_word;
  logic                   out_wr_en;
  logic [2:0]             fill_cnt;
`ifdef ASM_PARITY_EN
  logic                   in_par;
  logic                   parity_err;

  modport master (
    output in_byte, in_valid, flush, out_stall, in_par,
    input  in_ready, out_word, out_wr_en, fill_cnt, parity_err
  );
  modport slave (
    input  in_byte, in_valid, flush, out_stall, in_par,
    output in_ready, out_word, out_wr_en, fill_cnt, parity_err
  );
`else
  modport master (
    output in_byte, in_valid, flush, out_stall,
    input  in_ready, out_word, out_wr_en, fill_cnt
  );
  modport slave (
    input  in_byte, in_valid, flush, out_stall,
    output in_ready, out_word, out_wr_en, fill_cnt
  );
`endif
endinterface

// File: rtl/word40_assembler_byte_slot.sv
// One byte lane of the assembly buffer: decodes whether the incoming byte belongs
// to this lane and stores it. fwd_o shows the lane value including this cycle's write.
module asm_byte_slot
  import word40_assembler_pkg::*;
#(
  parameter int NBYTES    = 5,
  parameter int LANE      = 0,
  parameter int LSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [ASM_CNT_W-1:0]   cnt_i,
  input  logic [`ASM_BYTE_W-1:0] byte_i,
  output logic [`ASM_BYTE_W-1:0] q_o,
  output logic [`ASM_BYTE_W-1:0] fwd_o
);

  // Arrival index of the byte that lands in this lane.
  localparam logic [ASM_CNT_W-1:0] SLOT_IDX =
    ASM_CNT_W'((LSB_FIRST != 0) ? LANE : (NBYTES - 1 - LANE));

  logic                   hit;
  logic [`ASM_BYTE_W-1:0] byte_q;
  logic [`ASM_BYTE_W-1:0] byte_d;

  assign hit    = we_i && (cnt_i == SLOT_IDX);
  assign byte_d = hit ? byte_i : byte_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_q <= '0;
    end else begin
      byte_q <= byte_d;
    end
  end

  assign q_o   = byte_q;
  assign fwd_o = byte_d;

endmodule

// File: rtl/word40_assembler.sv
// Byte-serial to 40-bit word packer driving a write-enabled storage register.
// Define ASM_PARITY_EN to add per-byte even-parity checking and word dropping.
module word40_assembler
  import word40_assembler_pkg::*;
#(
  parameter int NBYTES    = 5,
  parameter int LSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  word40_assembler_if.slave     bus
);

  localparam int                     WORD_W   = `ASM_BYTE_W * NBYTES;
  localparam logic [ASM_CNT_W-1:0]   CNT_LAST = ASM_CNT_W'(NBYTES - 1);

  asm_state_e           state_q, state_d;
  logic [ASM_CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0]    out_word_q, out_word_d;
  logic                 out_wr_en_q, out_wr_en_d;

  logic [WORD_W-1:0]    asm_q;
  logic [WORD_W-1:0]    asm_fwd;
  logic                 in_ready;
  logic [ASM_CNT_W-1:0] fill_cnt;
  logic                 accept;
  logic                 last_byte;
  logic                 emit_fill;
  logic                 emit_full;
  logic                 emit_bad;

  assign accept    = bus.in_valid && in_ready && !bus.flush;
  assign last_byte = accept && (cnt_q == CNT_LAST);
  assign emit_fill = last_byte && !bus.out_stall;
  assign emit_full = (state_q == ASM_S_FULL) && !bus.flush && !bus.out_stall;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_slot
      asm_byte_slot #(
        .NBYTES    (NBYTES),
        .LANE      (gi),
        .LSB_FIRST (LSB_FIRST)
      ) u_slot (
        .clk    (clk),
        .rst    (rst),
        .we_i   (accept),
        .cnt_i  (cnt_q),
        .byte_i (bus.in_byte),
        .q_o    (asm_q[gi*`ASM_BYTE_W +: `ASM_BYTE_W]),
        .fwd_o  (asm_fwd[gi*`ASM_BYTE_W +: `ASM_BYTE_W])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ASM_S_FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush wins over everything; cnt returns to 0 whenever a word completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = ASM_S_FILL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ASM_S_FILL: begin
          if (last_byte) begin
            cnt_d = '0;
            if (bus.out_stall) state_d = ASM_S_FULL;
          end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ASM_S_FULL: begin
          cnt_d = '0;
          if (!bus.out_stall) state_d = ASM_S_FILL;
        end
        default: begin
          state_d = ASM_S_FILL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    fill_cnt = '0;
    if (state_q == ASM_S_FILL) begin
      in_ready = 1'b1;
      fill_cnt = cnt_q;
    end
  end

`ifdef ASM_PARITY_EN
  logic byte_bad;
  logic word_err_q, word_err_d;
  logic parity_err_q, parity_err_d;

  assign byte_bad = accept && asm_par_bad(bus.in_byte, bus.in_par);
  assign emit_bad = (emit_fill && (word_err_q || byte_bad)) || (emit_full && word_err_q);

  always_comb begin
    word_err_d   = word_err_q;
    parity_err_d = (emit_fill || emit_full) && emit_bad;
    if (bus.flush || emit_fill || emit_full) begin
      word_err_d = 1'b0;
    end else if (byte_bad) begin
      word_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_err_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      word_err_q   <= word_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign emit_bad = 1'b0;
`endif

  // Direct emit uses the forwarded buffer so the last byte is included without a bubble.
  always_comb begin
    out_wr_en_d = 1'b0;
    out_word_d  = out_word_q;
    if (emit_fill && !emit_bad) begin
      out_wr_en_d = 1'b1;
      out_word_d  = asm_fwd;
    end else if (emit_full && !emit_bad) begin
      out_wr_en_d = 1'b1;
      out_word_d  = asm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_word_q  <= '0;
      out_wr_en_q <= 1'b0;
    end else begin
      out_word_q  <= out_word_d;
      out_wr_en_q <= out_wr_en_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.fill_cnt  = fill_cnt;
  assign bus.out_word  = out_word_q;
  assign bus.out_wr_en = out_wr_en_q;

endmodule

// File: tb/tb_word40_assembler.sv
// Self-checking bench for word40_assembler: directed scenarios then random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_word40_assembler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  word40_assembler_if bus();

  word40_assembler #(
    .NBYTES    (5),
    .LSB_FIRST (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes of the partial word in arrival order, plus a held word.
  logic [7:0]  m_part[$];
  logic        m_full = 1'b0;
  logic        m_bad  = 1'b0;
  logic [39:0] m_held = '0;
  logic [39:0] m_word = '0;
  logic        m_wr   = 1'b0;
  logic        m_perr = 1'b0;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_emit(input logic [39:0] w);
    if (m_bad) m_perr = 1'b1;
    else begin
      m_wr   = 1'b1;
      m_word = w;
    end
    m_bad = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] b,
                            input logic fl, input logic st, input logic pbad);
    logic [39:0] w;
    if (!r) begin
      m_part.delete();
      m_full = 1'b0; m_bad = 1'b0; m_held = '0;
      m_word = '0;   m_wr  = 1'b0; m_perr = 1'b0;
      return;
    end
    m_wr   = 1'b0;
    m_perr = 1'b0;
    if (fl) begin
      m_part.delete();
      m_full = 1'b0;
      m_bad  = 1'b0;
    end else if (m_full) begin
      if (!st) begin
        model_emit(m_held);
        m_full = 1'b0;
      end
    end else if (v) begin
      m_part.push_back(b);
      m_bad = m_bad | pbad;
      if (m_part.size() == 5) begin
        w = '0;
        for (int i = 0; i < 5; i++) w = w | (40'(m_part[i]) << (8 * i));
        m_part.delete();
        if (st) begin
          m_full = 1'b1;
          m_held = w;
        end else begin
          model_emit(w);
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] b,
                      input logic fl, input logic st, input logic pbad);
    rst           = r;
    bus.in_valid  = v;
    bus.in_byte   = b;
    bus.flush     = fl;
    bus.out_stall = st;
`ifdef ASM_PARITY_EN
    bus.in_par    = (^b) ^ pbad;
`endif
    model_step(r, v, b, fl, st, pbad);
    @(posedge clk);
    #1;
    check("wr_en",    40'(bus.out_wr_en), 40'(m_wr));
    check("out_word", bus.out_word, m_word);
    check("fill_cnt", 40'(bus.fill_cnt), 40'(m_full ? 0 : m_part.size()));
    check("in_ready", 40'(bus.in_ready), 40'(!m_full));
`ifdef ASM_PARITY_EN
    check("parity_err", 40'(bus.parity_err), 40'(m_perr));
`endif
  endtask

  initial begin
    logic [7:0] seq_a [5];
    logic [7:0] seq_b [5];
    logic [39:0] prev_word;
    seq_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    seq_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    rst = 1'b0; bus.in_valid = 1'b0; bus.in_byte = '0; bus.flush = 1'b0; bus.out_stall = 1'b0;
`ifdef ASM_PARITY_EN
    bus.in_par = 1'b0;
`endif

    // Reset held three cycles with valid asserted
    repeat (3) step(1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    check("rst_wr_en", 40'(bus.out_wr_en), 40'h0);
    check("rst_word",  bus.out_word, 40'h0);
    check("rst_fill",  40'(bus.fill_cnt), 40'h0);
    check("rst_ready", 40'(bus.in_ready), 40'h1);

    // Back-to-back stream, then a byte accepted while wr_en is high
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, seq_a[i], 1'b0, 1'b0, 1'b0);
    check("stream_wr",   40'(bus.out_wr_en), 40'h1);
    check("stream_word", bus.out_word, 40'h5544332211);
    step(1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    check("stream_nodup", 40'(bus.out_wr_en), 40'h0);
    check("stream_next",  40'(bus.fill_cnt), 40'h1);

    // Last byte under stall held four cycles
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    check("stall_ready0", 40'(bus.in_ready), 40'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
      check("stall_ready", 40'(bus.in_ready), 40'h0);
      check("stall_nowr",  40'(bus.out_wr_en), 40'h0);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("stall_wr",   40'(bus.out_wr_en), 40'h1);
    check("stall_word", bus.out_word, 40'hA599887766);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("stall_nodup", 40'(bus.out_wr_en), 40'h0);

    // Flush after three bytes, with a byte presented in the flush cycle
    step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0);
    check("flush_fill", 40'(bus.fill_cnt), 40'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, seq_b[i], 1'b0, 1'b0, 1'b0);
    check("flush_wr",   40'(bus.out_wr_en), 40'h1);
    check("flush_word", bus.out_word, 40'hEEDDCCBBAA);

    // Flush while FULL together with a valid byte
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    check("fullflush_wr",    40'(bus.out_wr_en), 40'h0);
    check("fullflush_fill",  40'(bus.fill_cnt), 40'h0);
    check("fullflush_ready", 40'(bus.in_ready), 40'h1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("fullflush_nowr", 40'(bus.out_wr_en), 40'h0);
    check("fullflush_word", bus.out_word, 40'hEEDDCCBBAA);

`ifdef ASM_PARITY_EN
    // Bad parity on the second byte drops the word
    prev_word = bus.out_word;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'(i == 1));
    check("par_err",    40'(bus.parity_err), 40'h1);
    check("par_nowr",   40'(bus.out_wr_en), 40'h0);
    check("par_word",   bus.out_word, prev_word);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
    check("par_clear",  40'(bus.parity_err), 40'h0);
    check("par_nextwr", 40'(bus.out_wr_en), 40'h1);
    check("par_next",   bus.out_word, 40'hD4D3D2D1D0);
`else
    prev_word = bus.out_word;
    check("hold_word", bus.out_word, prev_word ^ 40'h0);
`endif

    // Randomized traffic, including mid-word resets, flushes and stalls
    for (int n = 0; n < 600; n++) begin
      logic r, v, fl, st, pb;
      r  = ($urandom_range(0, 99) != 0);
      v  = ($urandom_range(0, 9) < 7);
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 19) == 0);
`ifdef ASM_PARITY_EN
      pb = ($urandom_range(0, 19) == 0);
`else
      pb = 1'b0;
`endif
      step(r, v, 8'($urandom), fl, st, pb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
